// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO and a valid/ready push port.
// Bit timing comes from an external one-clk baud tick; frames may run back-to-back.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               tick,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_BITS-1:0]               in_data,
  output logic                               tx,
  output logic                               busy,
  output logic                               tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int BW = $clog2(DATA_BITS+1);

  localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] DATA_BITS_C = BW'(DATA_BITS);
  localparam logic [1:0]    STOP_BITS_C = 2'(STOP_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  // ---------------------------------------------------------------- FIFO
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 push, pop, fifo_nonempty;
  logic [DATA_BITS-1:0] head;

  // Based on the registered count only, so a same-cycle pop never frees a slot early.
  assign in_ready      = (count_q < DEPTH_C);
  assign push          = in_valid && in_ready;
  assign fifo_nonempty = (count_q != '0);
  assign head          = mem_q[rd_ptr_q];

  // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage is not reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------- TX FSM
  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]           stop_cnt_q, stop_cnt_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 tx_done_q, tx_done_d;
  logic                 data_last, stop_last, head_par;

  assign data_last = (bit_cnt_q >= DATA_BITS_C);
  assign stop_last = (stop_cnt_q >= STOP_BITS_C);
  assign head_par  = (PARITY_ODD != 0) ? ~^head : ^head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        S_IDLE:   if (fifo_nonempty) state_d = S_START;
        S_START:  state_d = S_DATA;
        S_DATA:   if (data_last) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        S_PARITY: state_d = S_STOP;
        S_STOP:   if (stop_last) state_d = fifo_nonempty ? S_START : S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    pop        = 1'b0;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    tx_done_d  = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          tx_d = 1'b1;
          pop  = fifo_nonempty;
        end
        S_START: begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = BW'(1);
        end
        S_DATA: begin
          if (!data_last) begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (PARITY_EN != 0) begin
            tx_d = par_q;
          end else begin
            tx_d       = 1'b1;
            stop_cnt_d = 2'd1;
          end
        end
        S_PARITY: begin
          tx_d       = 1'b1;
          stop_cnt_d = 2'd1;
        end
        S_STOP: begin
          if (!stop_last) begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end else begin
            tx_done_d = 1'b1;
            pop       = fifo_nonempty;
            busy_d    = fifo_nonempty;
            tx_d      = 1'b1;
          end
        end
        default: tx_d = 1'b1;
      endcase
    end
    // Loading a word always begins a frame: drive the start bit and latch its parity.
    if (pop) begin
      shift_d = head;
      par_d   = head_par;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign tx_done    = tx_done_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four configurations share clk, rst_n and tick.
// Instance 0 = 8N1, 1 = 8E1, 2 = 8O1, 3 = 7 data bits with 2 stop bits.
module tb_uart_tx_fifo;

  localparam int TICK_GAP = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       in_valid_w [4];
  logic [7:0] in_data_w  [3];
  logic [6:0] in_data_7;
  logic       tx_w       [4];
  logic       busy_w     [4];
  logic       tx_done_w  [4];
  logic       in_ready_w [4];
  logic [2:0] count_w    [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_fifo u_8n1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .in_valid(in_valid_w[0]), .in_ready(in_ready_w[0]),
    .in_data(in_data_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(tx_done_w[0]),
    .fifo_count(count_w[0])
  );

  uart_tx_fifo #(.PARITY_EN(1), .PARITY_ODD(0)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .in_valid(in_valid_w[1]), .in_ready(in_ready_w[1]),
    .in_data(in_data_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(tx_done_w[1]),
    .fifo_count(count_w[1])
  );

  uart_tx_fifo #(.PARITY_EN(1), .PARITY_ODD(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .in_valid(in_valid_w[2]), .in_ready(in_ready_w[2]),
    .in_data(in_data_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(tx_done_w[2]),
    .fifo_count(count_w[2])
  );

  uart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .in_valid(in_valid_w[3]), .in_ready(in_ready_w[3]),
    .in_data(in_data_7), .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(tx_done_w[3]),
    .fifo_count(count_w[3])
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts on a negedge, returns on the negedge right after the ticked posedge.
  task automatic send_tick();
    repeat (TICK_GAP-1) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic push(input int u, input logic [7:0] d);
    @(negedge clk);
    in_valid_w[u] = 1'b1;
    case (u)
      0:       in_data_w[0] = d;
      1:       in_data_w[1] = d;
      2:       in_data_w[2] = d;
      default: in_data_7    = d[6:0];
    endcase
    @(negedge clk);
    in_valid_w[u] = 1'b0;
  endtask

  // Whole frame from the start tick; bit i of tx_exp/done_exp is the value after tick i+1.
  task automatic ticks_expect(input int u, input int n, input logic [15:0] tx_exp,
                              input logic [15:0] done_exp, input string name);
    for (int i = 0; i < n; i++) begin
      send_tick();
      check($sformatf("%s tx t%0d", name, i+1), 16'(tx_w[u]), 16'(tx_exp[i]));
      check($sformatf("%s done t%0d", name, i+1), 16'(tx_done_w[u]), 16'(done_exp[i]));
    end
  endtask

  // 8N1 frame on instance 0 after its start tick: 8 data ticks, stop tick, end tick.
  task automatic frame_8n1(input logic [7:0] d, input logic b2b, input string name);
    logic exp_tx;
    for (int i = 0; i < 10; i++) begin
      send_tick();
      if (i < 8)       exp_tx = d[i];
      else if (i == 8) exp_tx = 1'b1;
      else             exp_tx = ~b2b;
      check($sformatf("%s tx t%0d", name, i+2), 16'(tx_w[0]), 16'(exp_tx));
      check($sformatf("%s done t%0d", name, i+2), 16'(tx_done_w[0]), 16'(i == 9));
    end
    check($sformatf("%s busy end", name), 16'(busy_w[0]), 16'(b2b));
  endtask

  initial begin
    rst_n = 1'b0;
    tick  = 1'b0;
    in_data_7 = '0;
    for (int i = 0; i < 4; i++) in_valid_w[i] = 1'b0;
    for (int i = 0; i < 3; i++) in_data_w[i]  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst tx", 16'(tx_w[0]), 16'd1);
    check("rst busy", 16'(busy_w[0]), 16'd0);
    check("rst tx_done", 16'(tx_done_w[0]), 16'd0);
    check("rst count", 16'(count_w[0]), 16'd0);
    check("rst in_ready", 16'(in_ready_w[0]), 16'd1);
    rst_n = 1'b1;

    // 8N1, 0x55
    push(0, 8'h55);
    check("t1 count after push", 16'(count_w[0]), 16'd1);
    send_tick();
    check("t1 start tx", 16'(tx_w[0]), 16'd0);
    check("t1 start busy", 16'(busy_w[0]), 16'd1);
    check("t1 count after pop", 16'(count_w[0]), 16'd0);
    frame_8n1(8'h55, 1'b0, "t1");
    @(negedge clk);
    check("t1 done one clk", 16'(tx_done_w[0]), 16'd0);
    check("t1 idle tx", 16'(tx_w[0]), 16'd1);

    // Even / odd parity, 0x07: 11-tick frames, parity bit 1 (even) and 0 (odd)
    push(1, 8'h07);
    ticks_expect(1, 12, 16'h0E0E, 16'h0800, "even");
    check("even busy end", 16'(busy_w[1]), 16'd0);
    push(2, 8'h07);
    ticks_expect(2, 12, 16'h0C0E, 16'h0800, "odd");
    check("odd busy end", 16'(busy_w[2]), 16'd0);

    // 7 data bits, 2 stop bits, 0x7F
    push(3, 8'h7F);
    ticks_expect(3, 11, 16'h07FE, 16'h0400, "7n2");
    check("7n2 busy end", 16'(busy_w[3]), 16'd0);

    // Fill the FIFO with ticks held off; a fifth word waits on in_valid
    @(negedge clk);
    in_valid_w[0] = 1'b1;
    in_data_w[0]  = 8'hA0;
    @(negedge clk) in_data_w[0] = 8'hA1;
    @(negedge clk) in_data_w[0] = 8'hA2;
    @(negedge clk) in_data_w[0] = 8'hA3;
    @(negedge clk) in_data_w[0] = 8'hA4;
    check("t3 full count", 16'(count_w[0]), 16'd4);
    check("t3 full in_ready", 16'(in_ready_w[0]), 16'd0);
    check("t3 no start without tick", 16'(busy_w[0]), 16'd0);
    @(negedge clk);
    check("t3 fifth held", 16'(count_w[0]), 16'd4);
    send_tick();
    check("t3 pop count", 16'(count_w[0]), 16'd3);
    check("t3 ready after pop", 16'(in_ready_w[0]), 16'd1);
    check("t3 start tx", 16'(tx_w[0]), 16'd0);
    @(negedge clk);
    in_valid_w[0] = 1'b0;
    check("t3 fifth accepted", 16'(count_w[0]), 16'd4);
    frame_8n1(8'hA0, 1'b1, "t3 A0");
    check("t3 count after A1 pop", 16'(count_w[0]), 16'd3);
    frame_8n1(8'hA1, 1'b1, "t3 A1");
    frame_8n1(8'hA2, 1'b1, "t3 A2");
    frame_8n1(8'hA3, 1'b1, "t3 A3");
    frame_8n1(8'hA4, 1'b0, "t3 A4");
    check("t3 drained", 16'(count_w[0]), 16'd0);

    // Reset during data bit 3 with two words queued
    push(0, 8'h00);
    push(0, 8'h11);
    push(0, 8'h22);
    send_tick();
    check("t5 queued", 16'(count_w[0]), 16'd2);
    repeat (4) send_tick();
    check("t5 bit3 low", 16'(tx_w[0]), 16'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5 async tx", 16'(tx_w[0]), 16'd1);
    check("t5 async count", 16'(count_w[0]), 16'd0);
    check("t5 async busy", 16'(busy_w[0]), 16'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_tick();
      check($sformatf("t5 idle tx k%0d", i), 16'(tx_w[0]), 16'd1);
      check($sformatf("t5 idle busy k%0d", i), 16'(busy_w[0]), 16'd0);
    end

    // Push into an empty FIFO on the same clk as a tick
    @(negedge clk);
    in_valid_w[0] = 1'b1;
    in_data_w[0]  = 8'h0F;
    tick          = 1'b1;
    @(negedge clk);
    in_valid_w[0] = 1'b0;
    tick          = 1'b0;
    check("t6 no start tx", 16'(tx_w[0]), 16'd1);
    check("t6 no start busy", 16'(busy_w[0]), 16'd0);
    check("t6 queued", 16'(count_w[0]), 16'd1);
    send_tick();
    check("t6 start tx", 16'(tx_w[0]), 16'd0);
    check("t6 start busy", 16'(busy_w[0]), 16'd1);
    frame_8n1(8'h0F, 1'b0, "t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
